maxpool_layer_2: RTL and testbench



---
 rtl/maxpool_layer_2.sv | 116 +++++++++++
 tb/tb_maxpool_layer_2.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/maxpool_layer_2.sv
// maxpool_layer_2: 2x2 / stride-2 max-pool over a binarized CH-channel pixel
// stream in raster order. Max over 1-bit values is an OR, so each pooled pixel
// is the OR of its four input pixels. A horizontal accumulator pairs adjacent
// columns, a half-width line buffer carries even-row pairs down to the odd row.
module maxpool_layer_2 #(
  parameter int unsigned IN_W = 8,
  parameter int unsigned IN_H = 8,
  parameter int unsigned CH   = 16
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [CH-1:0]                                  conv2_in,
  input  logic                                           valid_in,
  output logic [CH-1:0]                                  pool2_out,
  output logic                                           valid_out_pool2,
  output logic [$clog2((IN_W/2)*(IN_H/2))-1:0]           pool2_idx,
  output logic                                           frame_done
);

  localparam int unsigned OUT_W   = IN_W / 2;
  localparam int unsigned OUT_H   = IN_H / 2;
  localparam int unsigned OUT_N   = OUT_W * OUT_H;
  localparam int unsigned COL_W   = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int unsigned ROW_W   = (IN_H > 1) ? $clog2(IN_H) : 1;
  localparam int unsigned LB_W    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int unsigned IDX_W   = $clog2(OUT_N);

  // Raster position of the pixel currently on conv2_in.
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  // Even-column pixel waiting for its odd-column partner.
  logic [CH-1:0]    h_acc;

  // One horizontal pair per pooled column, written on even rows, read on odd.
  logic [CH-1:0]    linebuf [OUT_W];

  logic             col_last;
  logic             row_last;
  logic             col_odd;
  logic             row_odd;
  logic [LB_W-1:0]  lb_idx;
  logic [CH-1:0]    pair;
  logic [IDX_W-1:0] idx_next;
  logic             wr_line;
  logic             emit;

  // Position decode and the horizontal pair for the current pixel.
  always_comb begin
    col_last = (col == COL_W'(IN_W - 1));
    row_last = (row == ROW_W'(IN_H - 1));
    col_odd  = col[0];
    row_odd  = row[0];
    lb_idx   = LB_W'(col >> 1);
    pair     = h_acc | conv2_in;
    idx_next = IDX_W'(row >> 1) * IDX_W'(OUT_W) + IDX_W'(col >> 1);
    wr_line  = valid_in && !row_odd && col_odd;
    emit     = valid_in && row_odd && col_odd;
  end

  // Column/row counters advance only on accepted pixels and wrap per frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (valid_in) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Capture the left pixel of each horizontal pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_acc <= '0;
    end else if (valid_in && !col_odd) begin
      h_acc <= conv2_in;
    end
  end

  // Store even-row pairs; the next even row overwrites before any read, so no
  // clearing between frames is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(OUT_W); i++) begin
        linebuf[i] <= '0;
      end
    end else if (wr_line) begin
      linebuf[lb_idx] <= pair;
    end
  end

  // Pooled output: registered, pulses for one cycle, data/index hold between.
  always_ff @(posedge clk) begin
    if (rst) begin
      pool2_out       <= '0;
      valid_out_pool2 <= 1'b0;
      pool2_idx       <= '0;
      frame_done      <= 1'b0;
    end else begin
      valid_out_pool2 <= 1'b0;
      frame_done      <= 1'b0;
      if (emit) begin
        pool2_out       <= linebuf[lb_idx] | pair;
        valid_out_pool2 <= 1'b1;
        pool2_idx       <= idx_next;
        frame_done      <= row_last && col_last;
      end
    end
  end

endmodule

// File: tb/tb_maxpool_layer_2.sv
// Scoreboard bench for maxpool_layer_2: the driver pushes hand-computed pooled
// values when it sends each window's bottom-right pixel; a negedge monitor pops
// and compares data, index, frame_done and arrival cycle on every pulse.
module tb_maxpool_layer_2;

  localparam int unsigned IN_W  = 8;
  localparam int unsigned IN_H  = 8;
  localparam int unsigned CH    = 16;
  localparam int unsigned IDX_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [CH-1:0]    conv2_in;
  logic             valid_in;
  logic [CH-1:0]    pool2_out;
  logic             valid_out_pool2;
  logic [IDX_W-1:0] pool2_idx;
  logic             frame_done;

  maxpool_layer_2 #(.IN_W(IN_W), .IN_H(IN_H), .CH(CH)) dut (
    .clk             (clk),
    .rst             (rst),
    .conv2_in        (conv2_in),
    .valid_in        (valid_in),
    .pool2_out       (pool2_out),
    .valid_out_pool2 (valid_out_pool2),
    .pool2_idx       (pool2_idx),
    .frame_done      (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0]    data;
    logic [IDX_W-1:0] idx;
    logic             fd;
    int unsigned      stamp;
  } exp_t;

  exp_t          sb[$];
  int unsigned   pcnt = 0;
  int            checks = 0;
  int            fails = 0;
  int            fd_seen = 0;
  logic [CH-1:0] exp_frame [16];

  always @(posedge clk) pcnt <= pcnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Pixel patterns: 0 zeros, 1 ones, 2 single 0x0080 at (3,5), 3 checkerboard.
  function automatic logic [CH-1:0] pix(input int mode, input int r, input int c);
    case (mode)
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return (r == 3 && c == 5) ? 16'h0080 : 16'h0000;
      default: return ((r + c) % 2 == 0) ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  // Hand-derived pooled results for each pattern.
  task automatic set_exp(input int mode);
    for (int k = 0; k < 16; k++) begin
      case (mode)
        0: exp_frame[k] = 16'h0000;
        1: exp_frame[k] = 16'hFFFF;
        2: exp_frame[k] = (k == 6) ? 16'h0080 : 16'h0000;
        default: exp_frame[k] = 16'hFFFF;
      endcase
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_in = 1'b0;
      conv2_in = CH'($urandom);
    end
  endtask

  task automatic drive_pixel(input logic [CH-1:0] d, input int r, input int c);
    exp_t e;
    @(negedge clk);
    conv2_in = d;
    valid_in = 1'b1;
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      e.data  = exp_frame[(r / 2) * 4 + c / 2];
      e.idx   = IDX_W'((r / 2) * 4 + c / 2);
      e.fd    = (r == 7 && c == 7);
      e.stamp = pcnt + 1;
      sb.push_back(e);
    end
  endtask

  task automatic run_frame(input int mode, input int npix, input bit gaps);
    for (int i = 0; i < npix; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) idle($urandom_range(0, 5));
      drive_pixel(pix(mode, i / 8, i % 8), i / 8, i % 8);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    valid_in = 1'b1;
    conv2_in = 16'hFFFF;
    repeat (3) @(negedge clk);
    rst      = 1'b0;
    valid_in = 1'b0;
  endtask

  // Monitor: compares every pulse against the scoreboard and checks hold/idle.
  initial begin
    exp_t          e;
    logic [CH-1:0] hold_d;
    logic [IDX_W-1:0] hold_i;
    hold_d = '0;
    hold_i = '0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        hold_d = '0;
        hold_i = '0;
      end else if (valid_out_pool2 === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse_idx", 32'(pool2_idx), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("pool2_out", 32'(pool2_out), 32'(e.data));
          chk("pool2_idx", 32'(pool2_idx), 32'(e.idx));
          chk("frame_done", 32'(frame_done), 32'(e.fd));
          chk("latency_cycle", pcnt, e.stamp);
          hold_d = e.data;
          hold_i = e.idx;
        end
        if (frame_done === 1'b1) fd_seen++;
      end else begin
        chk("idle_valid", 32'(valid_out_pool2), 32'd0);
        chk("idle_frame_done", 32'(frame_done), 32'd0);
        chk("hold_pool2_out", 32'(pool2_out), 32'(hold_d));
        chk("hold_pool2_idx", 32'(pool2_idx), 32'(hold_i));
      end
    end
  end

  initial begin
    rst      = 1'b1;
    valid_in = 1'b0;
    conv2_in = '0;
    do_reset();

    // Reset state.
    @(negedge clk);
    chk("reset_pool2_out", 32'(pool2_out), 32'd0);
    chk("reset_valid", 32'(valid_out_pool2), 32'd0);
    chk("reset_idx", 32'(pool2_idx), 32'd0);
    chk("reset_frame_done", 32'(frame_done), 32'd0);

    // 1: all ones.
    set_exp(1); run_frame(1, 64, 1'b0); idle(4);
    // 2: single set bit at (3,5).
    set_exp(2); run_frame(2, 64, 1'b0); idle(4);
    // 3: checkerboard.
    set_exp(3); run_frame(3, 64, 1'b0); idle(4);
    // 4: test 2 with random input gaps.
    set_exp(2); run_frame(2, 64, 1'b1); idle(4);
    // 5: ones partial frame, reset after 37 pixels, then a zero frame.
    set_exp(1); run_frame(1, 37, 1'b0);
    do_reset();
    set_exp(0); run_frame(0, 64, 1'b0); idle(4);
    // 6: back-to-back ones frame then zeros frame.
    set_exp(1); run_frame(1, 64, 1'b0);
    set_exp(0); run_frame(0, 64, 1'b0);
    idle(1);

    for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1);
    idle(2);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    chk("frame_done_count", 32'(fd_seen), 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
